// File: rtl/seq_alu.sv
// seq_alu: handshaked XLEN-wide execute unit with a registered result.
// Base ALU ops complete in one cycle; RV32M-style multiply/divide iterate one
// bit per cycle when SEQ_ALU_MDU_EN is defined. Without that macro every M-op
// completes in one cycle with a zero result and no MDU datapath is built.
// Base selects use the shared `ALU_* encodings; fallbacks are defined here.

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`endif

module seq_alu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_busy
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] base_res;
  logic [SHW-1:0]  shamt;

  assign shamt = in_b[SHW-1:0];

  // Base ALU straight from the inputs; only consumed on the accept edge.
  always_comb begin
    base_res = '0;
    case (in_op[3:0])
      `ALU_ADD:  base_res = in_a + in_b;
      `ALU_SUB:  base_res = in_a - in_b;
      `ALU_SLL:  base_res = in_a << shamt;
      `ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      `ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      `ALU_XOR:  base_res = in_a ^ in_b;
      `ALU_SRL:  base_res = in_a >> shamt;
      `ALU_SRA:  base_res = $signed(in_a) >>> shamt;
      `ALU_OR:   base_res = in_a | in_b;
      `ALU_AND:  base_res = in_a & in_b;
      default:   base_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MDU_EN
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  // acc/lo hold the product halves (multiply) or remainder/quotient (divide)
  logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, mag_q, mag_d;
  logic            neg_q, neg_d;
  logic [2:0]      mop_q, mop_d;
  logic [SHW-1:0]  cnt_q, cnt_d;

  logic [2:0]      mop;
  logic            is_div, a_sgn, b_sgn, div_zero, div_ovf, mul_zero, special;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  // Accept-side decode: operand signedness, magnitudes and short-cut results.
  always_comb begin
    mop         = in_op[2:0];
    is_div      = mop[2];
    a_sgn       = in_a[XLEN-1] & (mop inside {3'd1, 3'd2, 3'd4, 3'd6});
    b_sgn       = in_b[XLEN-1] & (mop inside {3'd1, 3'd4, 3'd6});
    mag_a       = a_sgn ? -in_a : in_a;
    mag_b       = b_sgn ? -in_b : in_b;
    div_zero    = is_div & (in_b == '0);
    div_ovf     = is_div & ~mop[0] & (in_a == MinNeg) & (in_b == '1);
    mul_zero    = ~is_div & ((in_a == '0) | (in_b == '0));
    special     = div_zero | div_ovf | mul_zero;
    special_res = '0;
    if (div_zero) begin
      special_res = mop[1] ? in_a : '1;
    end else if (div_ovf) begin
      special_res = mop[1] ? '0 : in_a;
    end
  end

  logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
  logic              take;
  logic [XLEN-1:0]   mul_acc_n, mul_lo_n, div_acc_n, div_lo_n, step_acc, step_lo;
  logic [XLEN-1:0]   quo_s, rem_s, final_res;
  logic [2*XLEN-1:0] prod, prod_s;

  // One shift-add or restoring-divide step, plus the sign-corrected final value.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    mul_acc_n = mul_sum[XLEN:1];
    mul_lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
    rem_sh    = {acc_q, lo_q[XLEN-1]};
    rem_diff  = rem_sh - {1'b0, mag_q};
    take      = ~rem_diff[XLEN];
    div_acc_n = take ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    div_lo_n  = {lo_q[XLEN-2:0], take};
    step_acc  = mop_q[2] ? div_acc_n : mul_acc_n;
    step_lo   = mop_q[2] ? div_lo_n : mul_lo_n;
    prod      = {mul_acc_n, mul_lo_n};
    prod_s    = neg_q ? -prod : prod;
    quo_s     = neg_q ? -div_lo_n : div_lo_n;
    rem_s     = neg_q ? -div_acc_n : div_acc_n;
    if (mop_q[2]) begin
      final_res = mop_q[1] ? rem_s : quo_s;
    end else begin
      final_res = (mop_q[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
  end

  // Iteration state; only read in BUSY after being loaded, so no reset needed.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    lo_q  <= lo_d;
    mag_q <= mag_d;
    neg_q <= neg_d;
    mop_q <= mop_d;
    cnt_q <= cnt_d;
  end

  assign out_busy = (state_q == StBusy);
`else
  assign out_busy = 1'b0;
`endif

  // Next-state and datapath load for IDLE -> (BUSY) -> DONE -> IDLE.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
`ifdef SEQ_ALU_MDU_EN
    acc_d = acc_q;
    lo_d  = lo_q;
    mag_d = mag_q;
    neg_d = neg_q;
    mop_d = mop_q;
    cnt_d = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StDone;
          if (!in_op[4]) begin
            result_d = base_res;
          end else begin
`ifdef SEQ_ALU_MDU_EN
            if (special) begin
              result_d = special_res;
            end else begin
              state_d = StBusy;
              acc_d   = '0;
              mop_d   = mop;
              cnt_d   = SHW'(XLEN - 1);
              if (is_div) begin
                lo_d  = mag_a;
                mag_d = mag_b;
                // remainder follows the dividend, quotient the sign xor
                neg_d = mop[1] ? a_sgn : (a_sgn ^ b_sgn);
              end else begin
                lo_d  = mag_b;
                mag_d = mag_a;
                neg_d = a_sgn ^ b_sgn;
              end
            end
`else
            result_d = '0;
`endif
          end
        end
      end
      StBusy: begin
`ifdef SEQ_ALU_MDU_EN
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          result_d = final_res;
          state_d  = StDone;
        end
`else
        state_d = StIdle;
`endif
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state and result register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_result = result_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (XLEN=32) against a plain-arithmetic model.
// Expectations follow whether SEQ_ALU_MDU_EN is defined for the build.
module tb_seq_alu;

  localparam logic [3:0] OpAdd = 4'd0, OpSub = 4'd1, OpSll = 4'd2, OpSlt = 4'd3;
  localparam logic [3:0] OpSltu = 4'd4, OpXor = 4'd5, OpSrl = 4'd6, OpSra = 4'd7;
  localparam logic [3:0] OpOr = 4'd8, OpAnd = 4'd9;
  localparam logic [2:0] MMul = 3'd0, MMulh = 3'd1, MMulhsu = 3'd2, MMulhu = 3'd3;
  localparam logic [2:0] MDiv = 3'd4, MDivu = 3'd5, MRem = 3'd6, MRemu = 3'd7;
`ifdef SEQ_ALU_MDU_EN
  localparam bit MduEn = 1'b1;
`else
  localparam bit MduEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_busy;
  logic [4:0]  in_op;
  logic [31:0] in_a, in_b, out_result;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  seq_alu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_busy  (out_busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_base(logic [3:0] sel, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] s;
    s = $signed(a);
    case (sel)
      OpAdd:   return a + b;
      OpSub:   return a - b;
      OpSll:   return a << b[4:0];
      OpSlt:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OpSltu:  return (a < b) ? 32'd1 : 32'd0;
      OpXor:   return a ^ b;
      OpSrl:   return a >> b[4:0];
      OpSra:   return s >>> b[4:0];
      OpOr:    return a | b;
      OpAnd:   return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_special(logic [2:0] m, logic [31:0] a, logic [31:0] b);
    if (m[2]) return (b == 0) || (!m[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (a == 0) || (b == 0);
  endfunction

  function automatic logic [31:0] ref_m(logic [2:0] m, logic [31:0] a, logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    bit          ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (m)
      MMul:    begin p = sa * sb; return p[31:0]; end
      MMulh:   begin p = sa * sb; return p[63:32]; end
      MMulhsu: begin p = sa * ub; return p[63:32]; end
      MMulhu:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      MDiv:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : $signed(a) / $signed(b);
      MDivu:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MRem:    return (b == 0) ? a : ovf ? 32'd0 : $signed(a) % $signed(b);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    if (!op[4]) return ref_base(op[3:0], a, b);
    return MduEn ? ref_m(op[2:0], a, b) : 32'd0;
  endfunction

  function automatic int ref_lat(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    if (!op[4] || !MduEn) return 1;
    return is_special(op[2:0], a, b) ? 1 : 33;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Offers one op, then waits (bounded) for out_valid; latency counted from accept.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int busy);
    int w;
    res  = '0;
    lat  = 0;
    busy = 0;
    w    = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) return;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_busy === 1'b1) busy++;
      if (out_valid === 1'b1) break;
    end
    res = out_result;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_op = '0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    n_checks++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL reset_out_busy: got %b, expected 0", out_busy); end
    n_checks++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL reset_out_result: got %h, expected 0", out_result); end
    rst = 1'b0;
  endtask

  task automatic test_base();
    logic [31:0] res, exp;
    logic [4:0]  op;
    logic [31:0] a, b;
    int          lat, busy;
    issue({1'b0, OpAdd}, 32'h7FFF_FFFF, 32'd1, res, lat, busy);
    n_checks++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL add_ovf: got %h, expected 80000000", res); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d, expected 1", lat); end
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_handshake: got %b, expected 1", in_ready); end
    issue({1'b0, OpSra}, 32'h8000_0000, 32'h0000_003F, res, lat, busy);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sra_31: got %h, expected ffffffff", res); end
    issue({1'b0, OpSltu}, 32'd1, 32'hFFFF_FFFF, res, lat, busy);
    n_checks++; if (res !== 32'd1) begin n_fail++; $display("FAIL sltu: got %h, expected 1", res); end
    for (int i = 0; i < 32; i++) begin
      op  = {1'b0, 4'($urandom_range(0, 15))};
      a   = rand_operand();
      b   = rand_operand();
      exp = ref_result(op, a, b);
      issue(op, a, b, res, lat, busy);
      n_checks++; if (res !== exp) begin n_fail++; $display("FAIL base_rand op=%h a=%h b=%h: got %h, expected %h", op, a, b, res, exp); end
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL base_rand_latency op=%h: got %0d, expected 1", op, lat); end
    end
  endtask

  task automatic test_mdu();
    logic [2:0]  dm[7];
    logic [31:0] da[7], db[7], dexp[7];
    int          dlat[7];
    logic [31:0] res, exp, a, b;
    logic [4:0]  op;
    int          lat, busy, elat;
    dm = '{MMulhsu, MMul, MDiv, MRem, MDivu, MDiv, MRem};
    da = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
           32'h8000_0000, 32'h8000_0000};
    db = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    dexp = '{32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'h8000_0000, 32'd0};
    dlat = '{33, 33, 33, 33, 1, 1, 1};
    for (int i = 0; i < 7; i++) begin
      exp  = MduEn ? dexp[i] : 32'd0;
      elat = MduEn ? dlat[i] : 1;
      issue({2'b10, dm[i]}, da[i], db[i], res, lat, busy);
      n_checks++; if (res !== exp) begin n_fail++; $display("FAIL mdu_dir%0d m=%0d: got %h, expected %h", i, dm[i], res, exp); end
      n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL mdu_dir%0d_latency: got %0d, expected %0d", i, lat, elat); end
      n_checks++; if (busy !== elat - 1) begin n_fail++; $display("FAIL mdu_dir%0d_busy: got %0d, expected %0d", i, busy, elat - 1); end
    end
    for (int i = 0; i < 24; i++) begin
      op   = {2'b10, 3'($urandom_range(0, 7))};
      a    = rand_operand();
      b    = rand_operand();
      exp  = ref_result(op, a, b);
      elat = ref_lat(op, a, b);
      issue(op, a, b, res, lat, busy);
      n_checks++; if (res !== exp) begin n_fail++; $display("FAIL mdu_rand m=%0d a=%h b=%h: got %h, expected %h", op[2:0], a, b, res, exp); end
      n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL mdu_rand_latency m=%0d: got %0d, expected %0d", op[2:0], lat, elat); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res, exp;
    int          lat, busy;
    exp = MduEn ? 32'd14 : 32'd0;
    out_ready = 1'b0;
    issue({2'b10, MDivu}, 32'd100, 32'd7, res, lat, busy);
    n_checks++; if (res !== exp) begin n_fail++; $display("FAIL bp_divu: got %h, expected %h", res, exp); end
    in_valid = 1'b1; in_op = {1'b0, OpAdd}; in_a = 32'd1; in_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held c%0d: got %b, expected 1", i, out_valid); end
      n_checks++; if (out_result !== exp) begin n_fail++; $display("FAIL bp_result_held c%0d: got %h, expected %h", i, out_result, exp); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b, expected 0", i, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b, expected 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_req c%0d: got out_valid %b, expected 0", i, out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expq[$];
    logic [31:0] exp;
    int          results, overlap;
    bit          acc_now;
    results = 0;
    overlap = 0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_op = {1'b0, 4'($urandom_range(0, 9))}; in_a = $urandom; in_b = $urandom;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (out_valid === 1'b1) begin
        if (in_ready === 1'b1) overlap++;
        results++;
        if (expq.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL b2b_unexpected: got %h, expected no result", out_result);
        end else begin
          exp = expq.pop_front();
          n_checks++; if (out_result !== exp) begin n_fail++; $display("FAIL b2b_result: got %h, expected %h", out_result, exp); end
        end
      end
      acc_now = (in_ready === 1'b1);
      if (acc_now) expq.push_back(ref_result(in_op, in_a, in_b));
      @(posedge clk);
      #1;
      if (acc_now) begin
        in_op = {1'b0, 4'($urandom_range(0, 9))}; in_a = $urandom; in_b = $urandom;
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && expq.size() != 0) begin
        results++;
        exp = expq.pop_front();
        n_checks++; if (out_result !== exp) begin n_fail++; $display("FAIL b2b_drain: got %h, expected %h", out_result, exp); end
      end
    end
    n_checks++; if (results !== 12) begin n_fail++; $display("FAIL b2b_throughput: got %0d results, expected 12", results); end
    n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL b2b_ready_in_done: got %0d, expected 0", overlap); end
    n_checks++; if (expq.size() !== 0) begin n_fail++; $display("FAIL b2b_lost: got %0d pending, expected 0", expq.size()); end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] res;
    int          lat, busy, stale;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_op = {2'b10, MDiv}; in_a = 32'hFFFF_FC18; in_b = 32'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_busy_ready: got %b, expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_busy_valid: got %b, expected 0", out_valid); end
    n_checks++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_busy: got %b, expected 0", out_busy); end
    n_checks++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL rst_busy_result: got %h, expected 0", out_result); end
    rst = 1'b0;
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL rst_busy_stale: got %0d valid cycles, expected 0", stale); end
    issue({1'b0, OpAdd}, 32'd2, 32'd3, res, lat, busy);
    n_checks++; if (res !== 32'd5) begin n_fail++; $display("FAIL rst_recover_add: got %h, expected 5", res); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_base();
    test_mdu();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
